rv32i_exec_unit: RTL and testbench
==================================

# rv32i_exec_unit

Execute-stage datapath of the single-cycle RV32I core. Holds the 32×32-bit integer register file and the RV32I integer ALU. Operand B is selected between rs2 data and a decoded immediate, and the ALU result is written back to rd on the clock edge. The core's decoder drives all control inputs; this block contains no decode logic.

## Interface
- XLEN, 32: datapath width. Only 32 is supported.
- NREGS, 32: number of architectural registers. Address width is 5.
- clk  in  1  clock. Register writes happen on its rising edge.
- reset  in  1  reset, asynchronous, active-high. Clears every register to 0.
- rs1_addr  in  5  read address, port 1 (ALU operand A).
- rs2_addr  in  5  read address, port 2.
- rd_addr  in  5  write-back address.
- we  in  1  write enable for rd.
- imm  in  32  sign-extended immediate from the decoder.
- use_imm  in  1  operand B select: 1 = imm, 0 = rs2_data.
- alu_op  in  3  operation, equal to funct3.
- alu_alt  in  1  selects SUB instead of ADD, and SRA instead of SRL (instruction bit 30). The decoder forces it to 0 for ADDI.
- rs1_data  out  32  combinational read, port 1.
- rs2_data  out  32  combinational read, port 2.
- result  out  32  combinational ALU result; this is also the write-back data.

## Operation
- Operand A = rs1_data. Operand B = use_imm ? imm : rs2_data.
- alu_op encodings:
  - 000: ADD; SUB when alu_alt = 1. Arithmetic wraps modulo 2^32.
  - 001: SLL by B[4:0].
  - 010: SLT, signed. Result is 1 or 0.
  - 011: SLTU, unsigned. Result is 1 or 0.
  - 100: XOR.
  - 101: SRL by B[4:0]; SRA by B[4:0] when alu_alt = 1.
  - 110: OR.
  - 111: AND.
- alu_alt is ignored for every op other than 000 and 101.
- Shift amounts use only B[4:0]; B[31:5] are ignored.
- Register x0:
  - Reads always return 0.
  - Writes to x0 are discarded.
- Reads are combinational from the array. There is no bypass: a read of rd in the same cycle as its write returns the old value.
- Write: on the rising edge of clk, if we = 1 and rd_addr ≠ 0, then reg[rd_addr] ← result.
- Reading the same register on both ports is legal; both ports return the same value.

## Timing
- ALU and both read ports are purely combinational, with zero-cycle latency.
- Write latency is one cycle: the new value is visible on the read ports immediately after the capturing edge.
- Reset:
  - Asserting reset clears all registers to 0 immediately, without waiting for a clock edge.
  - While reset is high, writes are blocked, and rs1_data and rs2_data read 0.
  - result still reflects the current operands (imm when use_imm = 1).
- Reset asserted mid-operation: any write pending on that edge is lost.
- First write is possible on the first rising edge after reset deasserts.
- Simultaneous write and read of the same register: the read returns the pre-edge value until the edge.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode localparams: OP_IMM, OP, LOAD, STORE, BRANCH, LUI, JAL;
  - ALU op constants: ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SR, ALU_OR, ALU_AND;
  - XLEN.
- One natural sub-module: `exec_alu`, a combinational block (a, b, op, alt → y).
- The register-file array and operand mux stay in the top level of this block.

## Test plan
- Reset state: assert reset, release it, read x1 and x31 → both 0. Write x0 = 5 with we = 1 → x0 still reads 0.
- ADDI chain: x1 = x0 + 5, then x2 = x1 + (−3) → x1 = 5 and x2 = 2, each one cycle after its edge. With use_imm = 1, rd = 1, imm = 0x0000_0005: result = 5 before the edge.
- R-type ops, with x1 = 0xFFFF_FFF0 and x2 = 0x0000_0004:
  - SUB → 0xFFFF_FFEC.
  - SLT → 1.
  - SLTU → 0.
  - SRA → 0xFFFF_FFFF.
  - SRL → 0x0FFF_FFFF.
  - SLL → 0xFFFF_FF00.
  - XOR → 0xFFFF_FFF4.
  - OR → 0xFFFF_FFF4.
  - AND → 0x0000_0000.
- Shift masking: B = 0x0000_0021 with SLL of 1 → 0x0000_0002, since only the low 5 bits count.
- Write gating: we = 0 with result = 0x1234 to x3 → x3 is unchanged. Same-cycle read of x3 during a write of 7 → old value before the edge, 7 after.
- Async reset mid-run: set x5 = 0xDEAD_BEEF, then pulse reset between clock edges → x5 reads 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants for the execute slice.
// Holds XLEN, major opcodes and ALU operation (funct3) encodings.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational RV32I integer ALU.
// Ports: a, b operands; op = funct3; alt = bit 30 (SUB/SRA); y result.
module exec_alu
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            alt,
    output logic [XLEN-1:0] y
);

    // Only the low 5 bits of b form a shift amount.
    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = alt ? (a - b) : (a + b);
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  y = a ^ b;
            ALU_SR:   y = alt ? XLEN'($signed(a) >>> shamt)
                              : (a >> shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
        endcase
    end

endmodule

// File: rtl/rv32i_exec_unit.sv
// rv32i_exec_unit: execute stage with 32x32 register file and ALU.
// Ports: clk, reset (async, high); rs1/rs2/rd addresses, we, imm,
// use_imm, alu_op, alu_alt in; rs1_data, rs2_data, result out.
module rv32i_exec_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic            we,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [2:0]      alu_op,
    input  logic            alu_alt,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] op_b;

    // x0 is hardwired; reads are also forced to zero during reset.
    assign rs1_data = (reset || rs1_addr == 5'd0) ? '0
                                                   : regs[rs1_addr];
    assign rs2_data = (reset || rs2_addr == 5'd0) ? '0
                                                   : regs[rs2_addr];

    assign op_b = use_imm ? imm : rs2_data;

    exec_alu u_alu (
        .a   (rs1_data),
        .b   (op_b),
        .op  (alu_op),
        .alt (alu_alt),
        .y   (result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= result;
        end
    end

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// tb_rv32i_exec_unit: directed checks of rv32i_exec_unit.
// Linear stimulus with hand-computed expectations.
module tb_rv32i_exec_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        we;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    rv32i_exec_unit #(.XLEN(32), .NREGS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (rd_addr),
        .we       (we),
        .imm      (imm),
        .use_imm  (use_imm),
        .alu_op   (alu_op),
        .alu_alt  (alu_alt),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic w,
                       input logic [31:0] i, input logic ui,
                       input logic [2:0] op, input logic alt);
        rs1_addr = a1;
        rs2_addr = a2;
        rd_addr  = d;
        we       = w;
        imm      = i;
        use_imm  = ui;
        alu_op   = op;
        alu_alt  = alt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(5'd1, 5'd31, 5'd0, 1'b0, 32'd7, 1'b1, 3'b000, 1'b0);
        #10;
        chk("rst_rs1", rs1_data, 32'd0);
        chk("rst_result_imm", result, 32'd7);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_x1", rs1_data, 32'd0);
        chk("rst_x31", rs2_data, 32'd0);

        // write to x0 is discarded
        drv(5'd0, 5'd0, 5'd0, 1'b1, 32'd5, 1'b1, 3'b000, 1'b0);
        tick();
        chk("x0_rd", rs1_data, 32'd0);

        // ADDI x1 = x0 + 5
        drv(5'd0, 5'd1, 5'd1, 1'b1, 32'd5, 1'b1, 3'b000, 1'b0);
        chk("addi_res", result, 32'd5);
        chk("addi_nobypass", rs2_data, 32'd0);
        tick();
        drv(5'd1, 5'd0, 5'd2, 1'b1, 32'hFFFF_FFFD, 1'b1, 3'b000, 1'b0);
        chk("x1_eq5", rs1_data, 32'd5);
        chk("addi2_res", result, 32'd2);
        tick();
        drv(5'd2, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 3'b000, 1'b0);
        chk("x2_eq2", rs1_data, 32'd2);

        // x1 = 0xFFFFFFF0, x2 = 4, x4 = 1
        drv(5'd0, 5'd0, 5'd1, 1'b1, 32'hFFFF_FFF0, 1'b1, 3'b000, 1'b0);
        tick();
        drv(5'd0, 5'd0, 5'd2, 1'b1, 32'd4, 1'b1, 3'b000, 1'b0);
        tick();
        drv(5'd0, 5'd0, 5'd4, 1'b1, 32'd1, 1'b1, 3'b000, 1'b0);
        tick();

        // R-type on x1, x2
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b000, 1'b0);
        chk("rd_x1", rs1_data, 32'hFFFF_FFF0);
        chk("rd_x2", rs2_data, 32'h0000_0004);
        chk("add", result, 32'hFFFF_FFF4);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b000, 1'b1);
        chk("sub", result, 32'hFFFF_FFEC);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b010, 1'b0);
        chk("slt", result, 32'd1);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b010, 1'b1);
        chk("slt_alt", result, 32'd1);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b011, 1'b0);
        chk("sltu", result, 32'd0);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b101, 1'b1);
        chk("sra", result, 32'hFFFF_FFFF);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b101, 1'b0);
        chk("srl", result, 32'h0FFF_FFFF);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b001, 1'b0);
        chk("sll", result, 32'hFFFF_FF00);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b001, 1'b1);
        chk("sll_alt", result, 32'hFFFF_FF00);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b100, 1'b1);
        chk("xor", result, 32'hFFFF_FFF4);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b110, 1'b0);
        chk("or", result, 32'hFFFF_FFF4);
        drv(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0, 3'b111, 1'b0);
        chk("and", result, 32'h0000_0000);

        // shift amount masking
        drv(5'd4, 5'd0, 5'd0, 1'b0, 32'h21, 1'b1, 3'b001, 1'b0);
        chk("sll_mask", result, 32'h0000_0002);
        drv(5'd1, 5'd0, 5'd0, 1'b0, 32'h24, 1'b1, 3'b101, 1'b0);
        chk("srl_mask", result, 32'h0FFF_FFFF);

        // write gating
        drv(5'd0, 5'd0, 5'd3, 1'b0, 32'h1234, 1'b1, 3'b000, 1'b0);
        chk("wg_res", result, 32'h1234);
        tick();
        drv(5'd3, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 3'b000, 1'b0);
        chk("wg_x3", rs1_data, 32'd0);
        drv(5'd0, 5'd3, 5'd3, 1'b1, 32'd7, 1'b1, 3'b000, 1'b0);
        chk("same_cyc_old", rs2_data, 32'd0);
        tick();
        chk("same_cyc_new", rs2_data, 32'd7);
        drv(5'd3, 5'd3, 5'd0, 1'b0, 32'd0, 1'b0, 3'b000, 1'b0);
        chk("dual_p1", rs1_data, 32'd7);
        chk("dual_p2", rs2_data, 32'd7);
        chk("dual_add", result, 32'd14);

        // async reset between edges
        drv(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 3'b000, 1'b0);
        tick();
        drv(5'd5, 5'd3, 5'd6, 1'b1, 32'h55, 1'b1, 3'b000, 1'b0);
        chk("x5_set", rs1_data, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        chk("arst_x5", rs1_data, 32'd0);
        chk("arst_x3", rs2_data, 32'd0);
        chk("arst_result", result, 32'h55);
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_nowrite", rs1_data, 32'd0);
        drv(5'd0, 5'd6, 5'd6, 1'b1, 32'd9, 1'b1, 3'b000, 1'b0);
        chk("x6_pre", rs2_data, 32'd0);
        tick();
        chk("first_wr", rs2_data, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
